// File: rtl/fir_sched_ctrl.sv
// Sequencer for a 4x P_TAPS polyphase FIR: clears the MACs, steps the shared tap address,
// walks the final-sum mux, then pulses output valid. Optional overrun flag: FIR_SCHED_OVERRUN_EN.
module fir_sched_ctrl #(
   parameter int unsigned P_TAPS = 10
) (
   input  logic       iClk12M,
   input  logic       iRsn,
   input  logic       iEnSample600k,
   input  logic       iRun,
   input  logic       iClrErr,
   output logic       oMacClr,
   output logic       oEnMac,
   output logic [3:0] oCoeffAddr,
   output logic       oEnDelay,
   output logic [1:0] oModuleSel,
   output logic       oEnOut,
   output logic       oBusy,
   output logic       oOverrun
);

   typedef enum logic [2:0] {S_IDLE, S_CLR, S_MAC, S_SEL, S_DONE} state_t;

   localparam logic [3:0] LAST_TAP = 4'(P_TAPS - 1);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;

   logic       mac_clr_d, en_mac_d, en_delay_d, en_out_d, busy_d;
   logic [3:0] addr_d;
   logic [1:0] sel_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = 4'd0;
      unique case (state_q)
         S_IDLE: if (iRun && iEnSample600k) state_d = S_CLR;
         S_CLR:  state_d = S_MAC;
         S_MAC: begin
            if (cnt_q == LAST_TAP) state_d = S_SEL;
            else                   cnt_d   = cnt_q + 4'd1;
         end
         S_SEL: begin
            if (cnt_q == 4'd3) state_d = S_DONE;
            else               cnt_d   = cnt_q + 4'd1;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from next state and flopped, so they line up with state_q.
   always_comb begin
      mac_clr_d  = (state_d == S_CLR);
      en_mac_d   = (state_d == S_MAC);
      addr_d     = (state_d == S_MAC) ? cnt_d : 4'd0;
      en_delay_d = (state_d == S_SEL);
      sel_d      = (state_d == S_SEL) ? cnt_d[1:0] : 2'd0;
      en_out_d   = (state_d == S_DONE);
      busy_d     = (state_d != S_IDLE);
   end

   always_ff @(posedge iClk12M or negedge iRsn) begin
      if (!iRsn) begin
         state_q    <= S_IDLE;
         cnt_q      <= 4'd0;
         oMacClr    <= 1'b0;
         oEnMac     <= 1'b0;
         oCoeffAddr <= 4'd0;
         oEnDelay   <= 1'b0;
         oModuleSel <= 2'd0;
         oEnOut     <= 1'b0;
         oBusy      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         oMacClr    <= mac_clr_d;
         oEnMac     <= en_mac_d;
         oCoeffAddr <= addr_d;
         oEnDelay   <= en_delay_d;
         oModuleSel <= sel_d;
         oEnOut     <= en_out_d;
         oBusy      <= busy_d;
      end
   end

`ifdef FIR_SCHED_OVERRUN_EN
   // A strobe landing in any non-idle state (DONE included) is dropped and flagged; set beats clear.
   logic overrun_q, overrun_d;

   always_comb begin
      overrun_d = overrun_q;
      if (iClrErr)                                 overrun_d = 1'b0;
      if (iEnSample600k && (state_q != S_IDLE))    overrun_d = 1'b1;
   end

   always_ff @(posedge iClk12M or negedge iRsn) begin
      if (!iRsn) overrun_q <= 1'b0;
      else       overrun_q <= overrun_d;
   end

   assign oOverrun = overrun_q;
`else
   logic unused_clr_err;
   assign unused_clr_err = iClrErr;
   assign oOverrun       = 1'b0;
`endif

endmodule

// File: tb/tb_fir_sched_ctrl.sv
// Directed bench for fir_sched_ctrl: one P_TAPS=10 and one P_TAPS=2 instance share stimulus.
module tb_fir_sched_ctrl;

`ifdef FIR_SCHED_OVERRUN_EN
   localparam logic OVR = 1'b1;
`else
   localparam logic OVR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rsn = 1'b0;
   logic en_smp = 1'b0;
   logic run = 1'b0;
   logic clr_err = 1'b0;

   logic       a_mc, a_em, a_ed, a_eo, a_bz, a_ov;
   logic [3:0] a_ad;
   logic [1:0] a_ms;
   logic       b_mc, b_em, b_ed, b_eo, b_bz, b_ov;
   logic [3:0] b_ad;
   logic [1:0] b_ms;

   int checks = 0;
   int errors = 0;
   int pulses_a, pulses_b, s;
   logic ov_exp;

   always #5 clk = ~clk;

   fir_sched_ctrl #(.P_TAPS(10)) dut10 (
      .iClk12M(clk), .iRsn(rsn), .iEnSample600k(en_smp), .iRun(run), .iClrErr(clr_err),
      .oMacClr(a_mc), .oEnMac(a_em), .oCoeffAddr(a_ad), .oEnDelay(a_ed),
      .oModuleSel(a_ms), .oEnOut(a_eo), .oBusy(a_bz), .oOverrun(a_ov));

   fir_sched_ctrl #(.P_TAPS(2)) dut2 (
      .iClk12M(clk), .iRsn(rsn), .iEnSample600k(en_smp), .iRun(run), .iClrErr(clr_err),
      .oMacClr(b_mc), .oEnMac(b_em), .oCoeffAddr(b_ad), .oEnDelay(b_ed),
      .oModuleSel(b_ms), .oEnOut(b_eo), .oBusy(b_bz), .oOverrun(b_ov));

   task automatic chk(string name, logic [7:0] obs, logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   // d = cycles since the accepted strobe; expected outputs follow the fixed schedule.
   task automatic chk_all(string tag, int c, int d, int p, logic ovr_e,
                          logic mc, logic em, logic [3:0] ad, logic ed,
                          logic [1:0] ms, logic eo, logic bz, logic ov);
      logic       e_mc, e_em, e_ed, e_eo, e_bz;
      logic [3:0] e_ad;
      logic [1:0] e_ms;
      string      t;
      e_mc = (d == 1);
      e_em = (d >= 2) && (d <= p + 1);
      e_ad = e_em ? 4'(d - 2) : 4'd0;
      e_ed = (d >= p + 2) && (d <= p + 5);
      e_ms = e_ed ? 2'(d - p - 2) : 2'd0;
      e_eo = (d == p + 6);
      e_bz = (d >= 1) && (d <= p + 6);
      t = $sformatf("%s p%0d c%0d", tag, p, c);
      chk({t, " mac_clr"},  {7'd0, mc}, {7'd0, e_mc});
      chk({t, " en_mac"},   {7'd0, em}, {7'd0, e_em});
      chk({t, " addr"},     {4'd0, ad}, {4'd0, e_ad});
      chk({t, " en_delay"}, {7'd0, ed}, {7'd0, e_ed});
      chk({t, " mod_sel"},  {6'd0, ms}, {6'd0, e_ms});
      chk({t, " en_out"},   {7'd0, eo}, {7'd0, e_eo});
      chk({t, " busy"},     {7'd0, bz}, {7'd0, e_bz});
      chk({t, " overrun"},  {7'd0, ov}, {7'd0, ovr_e});
   endtask

   task automatic chk_both(string tag, int c, int d, logic ovr_e);
      chk_all(tag, c, d, 10, ovr_e, a_mc, a_em, a_ad, a_ed, a_ms, a_eo, a_bz, a_ov);
      chk_all(tag, c, d, 2,  ovr_e, b_mc, b_em, b_ad, b_ed, b_ms, b_eo, b_bz, b_ov);
   endtask

   task automatic do_reset();
      rsn = 1'b0; en_smp = 1'b0; run = 1'b0; clr_err = 1'b0;
      #1;
      chk_both("reset", 0, -100, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rsn = 1'b1;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Single sample: P=10 ends with en_out at 16, P=2 at 8.
      @(posedge clk); #1;
      do_reset();
      for (int c = 0; c <= 20; c++) begin
         run = 1'b1; en_smp = (c == 0);
         chk_both("single", c, c, 1'b0);
         next_cycle();
      end

      // Five back-to-back samples every 20 clocks.
      do_reset();
      pulses_a = 0; pulses_b = 0;
      for (int c = 0; c <= 100; c++) begin
         run = 1'b1; en_smp = (c % 20 == 0) && (c <= 80);
         s = (c == 0) ? 0 : ((c - 1) / 20) * 20;
         if (s > 80) s = 80;
         chk_both("stream", c, c - s, 1'b0);
         pulses_a += int'(a_eo); pulses_b += int'(b_eo);
         next_cycle();
      end
      chk("stream pulses p10", 8'(pulses_a), 8'd5);
      chk("stream pulses p2",  8'(pulses_b), 8'd5);

      // Strobes while busy are dropped (P=2 sees one in DONE); overrun set/clear/priority.
      do_reset();
      for (int c = 0; c <= 50; c++) begin
         run = 1'b1;
         en_smp  = (c == 0) || (c == 8) || (c == 30) || (c == 32) || (c == 35);
         clr_err = (c == 20) || (c == 35) || (c == 40);
         s = (c <= 30) ? 0 : 30;
         ov_exp = OVR && (((c >= 9) && (c <= 20)) || ((c >= 33) && (c <= 40)));
         chk_both("busy", c, c - s, ov_exp);
         next_cycle();
      end
      clr_err = 1'b0;

      // iRun dropped mid-sequence: completes, later strobe ignored.
      do_reset();
      for (int c = 0; c <= 30; c++) begin
         run = (c < 5); en_smp = (c == 0) || (c == 20);
         chk_both("run_drop", c, c, 1'b0);
         next_cycle();
      end

      // Asynchronous reset mid-sequence, then a clean restart.
      do_reset();
      for (int c = 0; c <= 6; c++) begin
         run = 1'b1; en_smp = (c == 0);
         chk_both("pre_rst", c, c, 1'b0);
         next_cycle();
      end
      rsn = 1'b0;
      #1;
      chk_both("async_rst", 7, -100, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rsn = 1'b1;
      for (int k = 0; k <= 22; k++) begin
         run = 1'b1; en_smp = (k == 3);
         chk_both("post_rst", k, k - 3, 1'b0);
         next_cycle();
      end
      en_smp = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fir_sched_ctrl.md
FIR_SCHED_CTRL -- requirements
Module: fir_sched_ctrl

Interface
REQ-001 Parameter: P_TAPS, 10, taps per MAC module (legal 2..15); total filter length 4*P_TAPS.
REQ-002 iClk12M  in  1  system clock, 12 MHz.
REQ-003 iRsn  in  1  reset; asynchronous, active-low.
REQ-004 iEnSample600k  in  1  one-cycle sample strobe, nominally every 20 clocks.
REQ-005 iRun  in  1  level enable; low keeps block idle.
REQ-006 iClrErr  in  1  one-cycle clear of overrun flag.
REQ-007 oMacClr  out  1  one-cycle accumulator clear to all four MACs.
REQ-008 oEnMac  out  1  MAC accumulate enable.
REQ-009 oCoeffAddr  out  4  coefficient/tap address shared by the four MACs.
REQ-010 oEnDelay  out  1  high while final-sum stage is capturing partial sums.
REQ-011 oModuleSel  out  2  selects MAC 0..3 into the final-sum stage.
REQ-012 oEnOut  out  1  one-cycle "filter output valid" pulse.
REQ-013 oBusy  out  1  high in every state except IDLE.
REQ-014 oOverrun  out  1  sticky overrun flag (see Configuration).

Function
REQ-015 All outputs SHALL be registered; no combinational input-to-output path.
REQ-016 FSM states SHALL be IDLE, CLR, MAC, SEL, DONE.
REQ-017 IDLE -> CLR on a clock where iRun=1 and iEnSample600k=1; otherwise stay IDLE.
REQ-018 CLR: oMacClr=1, oCoeffAddr=0, for exactly one cycle; then MAC.
REQ-019 MAC: oEnMac=1 for exactly P_TAPS cycles, oCoeffAddr = 0,1,...,P_TAPS-1; after address P_TAPS-1 go to SEL.
REQ-020 SEL: oEnDelay=1 for exactly 4 cycles, oModuleSel = 00,01,10,11 in order; then DONE.
REQ-021 DONE: oEnOut=1 for one cycle; then IDLE.
REQ-022 Latency: strobe accepted at cycle N -> oMacClr at N+1, first oEnMac at N+2, first oEnDelay at N+P_TAPS+2, oEnOut at N+P_TAPS+6 (N+16 at P_TAPS=10).
REQ-023 Outside their active states oMacClr, oEnMac, oEnDelay, oEnOut SHALL be 0; oCoeffAddr and oModuleSel SHALL be 0.
REQ-024 iEnSample600k while oBusy=1 (including DONE) SHALL be ignored; the running sequence is not restarted or extended.
REQ-025 iRun falling mid-sequence SHALL NOT abort; the sequence completes to IDLE, and no new one starts while iRun=0.
REQ-026 Strobe arriving in the same cycle the FSM returns from DONE to IDLE SHALL be ignored (DONE counts as busy).
REQ-027 oCoeffAddr SHALL never exceed P_TAPS-1; the tap counter does not wrap within a sequence.

Reset
REQ-028 iRsn low SHALL asynchronously force IDLE and all outputs to 0, including oOverrun, at any point mid-sequence.
REQ-029 After iRsn release, the first strobe with iRun=1 SHALL start a complete, normal sequence.

Configuration
REQ-030 Macro FIR_SCHED_OVERRUN_EN defined: a strobe ignored under REQ-024 sets oOverrun to 1 on the next clock; oOverrun holds until iClrErr=1 or reset; simultaneous set and iClrErr SHALL leave oOverrun=1.
REQ-031 Macro undefined: oOverrun is constant 0, iClrErr is ignored, and no overrun logic is present.

Verification
REQ-032 Reset, iRun=1, one strobe at cycle 0 -> oMacClr at 1; oEnMac at 2..11 with addr 0..9; oEnDelay at 12..15 with sel 0..3; oEnOut at 16; oBusy 1..16.
REQ-033 Strobes every 20 clocks, 5 samples -> exactly 5 oEnOut pulses, 20 clocks apart, oOverrun=0.
REQ-034 Second strobe at cycle 8 (MAC state) -> ignored, single oEnOut at 16; with FIR_SCHED_OVERRUN_EN oOverrun=1 from cycle 9 until iClrErr.
REQ-035 iRun dropped at cycle 5 -> sequence completes (oEnOut at 16); strobe at cycle 20 -> no activity.
REQ-036 iRsn asserted at cycle 7 -> all outputs 0 immediately; after release, a strobe at release+3 -> full sequence, oEnOut 16 cycles later.
REQ-037 P_TAPS=2 rebuild, strobe at 0 -> oEnMac at 2..3, oEnDelay at 4..7, oEnOut at 8.
